// File: rtl/seg_bcd_counter_if.sv
// Bus bundle between the BCD counter and its controller / display path.
// The ovf signal exists only when SEG_BCD_SATURATE_EN is defined.
interface seg_bcd_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic                    up_dn;
    logic                    clr;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    carry_out;
    logic [NUM_DIGITS-1:0]   blank;
`ifdef SEG_BCD_SATURATE_EN
    logic                    ovf;
`endif

    // Controller side: drives the commands, observes the count.
    modport master (
        output en, up_dn, clr, load, load_val,
`ifdef SEG_BCD_SATURATE_EN
        input  ovf,
`endif
        input  digits, carry_out, blank
    );

    // Counter side.
    modport slave (
        input  en, up_dn, clr, load, load_val,
`ifdef SEG_BCD_SATURATE_EN
        output ovf,
`endif
        output digits, carry_out, blank
    );
endinterface

// File: rtl/seg_bcd_counter.sv
// Multi-digit up/down BCD counter with clear, load, configurable top-digit modulus.
// Define SEG_BCD_SATURATE_EN to hold at the terminal value (with sticky ovf) instead of wrapping.
module seg_bcd_counter #(
    parameter int NUM_DIGITS = 4,
    parameter int MSD_MAX    = 9
) (
    input  logic                i_clk,
    input  logic                i_reset,
    seg_bcd_counter_if.slave    bus
);
    localparam int W = 4 * NUM_DIGITS;

    logic [W-1:0]          r_digits;
    logic [W-1:0]          w_step_val;
    logic [W-1:0]          w_load_val;
    logic [NUM_DIGITS-1:0] w_blank;
    logic                  w_term_up;
    logic                  w_term_dn;
    logic                  w_terminal;
`ifdef SEG_BCD_SATURATE_EN
    logic                  r_ovf;
`endif

    function automatic logic [3:0] digit_max(input int idx);
        return (idx == NUM_DIGITS - 1) ? 4'(MSD_MAX) : 4'd9;
    endfunction

    // Ripple the "all lower digits at max / at zero" enables from the LSD upward.
    always_comb begin
        logic       v_lo_max;
        logic       v_lo_zero;
        logic [3:0] v_d;
        logic [3:0] v_mx;
        w_step_val = r_digits;
        v_lo_max   = 1'b1;
        v_lo_zero  = 1'b1;
        v_d        = '0;
        v_mx       = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            v_d  = r_digits[4*i +: 4];
            v_mx = digit_max(i);
            if (bus.up_dn) begin
                if (v_lo_max)
                    w_step_val[4*i +: 4] = (v_d >= v_mx) ? 4'd0 : v_d + 4'd1;
            end else begin
                if (v_lo_zero)
                    w_step_val[4*i +: 4] = (v_d == 4'd0) ? v_mx : v_d - 4'd1;
            end
            v_lo_max  = v_lo_max  & (v_d == v_mx);
            v_lo_zero = v_lo_zero & (v_d == 4'd0);
        end
        w_term_up = v_lo_max;
        w_term_dn = v_lo_zero;
    end

    assign w_terminal = bus.up_dn ? w_term_up : w_term_dn;

    // Out-of-range load nibbles are replaced by 0 so the count never holds a non-BCD digit.
    always_comb begin
        w_load_val = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.load_val[4*i +: 4] <= digit_max(i))
                w_load_val[4*i +: 4] = bus.load_val[4*i +: 4];
        end
    end

    // Leading-zero mask, scanned from the MSD down; the LSD is always shown.
    always_comb begin
        logic v_zero_above;
        w_blank      = '0;
        v_zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            v_zero_above = v_zero_above & (r_digits[4*i +: 4] == 4'd0);
            w_blank[i]   = v_zero_above;
        end
        w_blank[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_digits <= '0;
`ifdef SEG_BCD_SATURATE_EN
            r_ovf    <= 1'b0;
`endif
        end else if (bus.clr) begin
            r_digits <= '0;
`ifdef SEG_BCD_SATURATE_EN
            r_ovf    <= 1'b0;
`endif
        end else if (bus.load) begin
            r_digits <= w_load_val;
`ifdef SEG_BCD_SATURATE_EN
            r_ovf    <= 1'b0;
`endif
        end else if (bus.en) begin
`ifdef SEG_BCD_SATURATE_EN
            if (w_terminal)
                r_ovf    <= 1'b1;
            else
                r_digits <= w_step_val;
`else
            // Stepping from the terminal value naturally wraps to all-0 / all-max.
            r_digits <= w_step_val;
`endif
        end
    end

    assign bus.digits = r_digits;
    assign bus.blank  = w_blank;
`ifdef SEG_BCD_SATURATE_EN
    assign bus.ovf       = r_ovf;
    assign bus.carry_out = 1'b0;
`else
    assign bus.carry_out = bus.en & ~bus.clr & ~bus.load & w_terminal;
`endif

endmodule
